// File: rtl/gobang_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gobang_move_ctrl
// Brief    : Game-flow controller ahead of gobang_display. Validates and
//            sequences placements, keeps a LIFO move history for undo, and
//            tracks side to move, win and draw status.
// Revision : 1.0 - initial release
// ============================================================================
module gobang_move_ctrl #(
    parameter int BOARD     = 15,
    parameter int MAX_MOVES = 225
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       start,
    input  logic       place_req,
    input  logic [3:0] place_i,
    input  logic [3:0] place_j,
    input  logic       retract_req,
    input  logic       cell_empty,
    input  logic       check_done,
    input  logic       check_win,
    output logic [3:0] consider_i,
    output logic [3:0] consider_j,
    output logic       clr,
    output logic       write,
    output logic       retract,
    output logic [3:0] write_i,
    output logic [3:0] write_j,
    output logic       write_color,
    output logic       crt_player,
    output logic       game_running,
    output logic [1:0] winner,
    output logic       draw,
    output logic [7:0] move_cnt,
    output logic       reject
);

    localparam logic [3:0] C_BOARD     = 4'(BOARD);
    localparam logic [7:0] C_MAX_MOVES = 8'(MAX_MOVES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_READY   = 3'd2,
        S_CHECK   = 3'd3,
        S_WRITE   = 3'd4,
        S_JUDGE   = 3'd5,
        S_RETRACT = 3'd6,
        S_OVER    = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] consider_i_q, consider_i_d;
    logic [3:0] consider_j_q, consider_j_d;
    logic       clr_q, clr_d;
    logic       write_q, write_d;
    logic       retract_q, retract_d;
    logic [3:0] wr_i_q, wr_i_d;
    logic [3:0] wr_j_q, wr_j_d;
    logic       wr_color_q, wr_color_d;
    logic       crt_player_q, crt_player_d;
    logic       running_q, running_d;
    logic [1:0] winner_q, winner_d;
    logic       draw_q, draw_d;
    logic [7:0] move_cnt_q, move_cnt_d;
    logic       reject_q, reject_d;
    logic [7:0] ptr_q, ptr_d;

    // Move history: {row, col} per stone; color is implied by stack depth
    logic [7:0] hist_mem [256];
    logic       w_hist_we;
    logic [7:0] w_pop;
    logic [7:0] w_cnt_m1;
    logic       w_do_retract;

    assign w_pop    = hist_mem[ptr_q - 8'd1];
    assign w_cnt_m1 = move_cnt_q - 8'd1;

    // Next-state and next-output logic; strobes default low, data outputs hold
    always_comb begin
        state_d      = state_q;
        consider_i_d = consider_i_q;
        consider_j_d = consider_j_q;
        clr_d        = 1'b0;
        write_d      = 1'b0;
        retract_d    = 1'b0;
        reject_d     = 1'b0;
        wr_i_d       = wr_i_q;
        wr_j_d       = wr_j_q;
        wr_color_d   = wr_color_q;
        crt_player_d = crt_player_q;
        running_d    = running_q;
        winner_d     = winner_q;
        draw_d       = draw_q;
        move_cnt_d   = move_cnt_q;
        ptr_d        = ptr_q;
        w_hist_we    = 1'b0;
        w_do_retract = 1'b0;

        if (start && (state_q != S_CLEAR)) begin
            // New game overrides any pending activity
            state_d = S_CLEAR;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    running_d = 1'b0;
                end
                S_CLEAR: begin
                    ptr_d        = 8'd0;
                    move_cnt_d   = 8'd0;
                    winner_d     = 2'b00;
                    draw_d       = 1'b0;
                    crt_player_d = 1'b0;
                    running_d    = 1'b1;
                    state_d      = S_READY;
                end
                S_READY: begin
                    if (retract_req && (move_cnt_q != 8'd0)) begin
                        w_do_retract = 1'b1;
                    end else if (place_req) begin
                        consider_i_d = place_i;
                        consider_j_d = place_j;
                        if ((place_i >= C_BOARD) || (place_j >= C_BOARD)) begin
                            reject_d = 1'b1;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (cell_empty) begin
                        write_d    = 1'b1;
                        wr_i_d     = consider_i_q;
                        wr_j_d     = consider_j_q;
                        wr_color_d = crt_player_q;
                        state_d    = S_WRITE;
                    end else begin
                        reject_d = 1'b1;
                        state_d  = S_READY;
                    end
                end
                S_WRITE: begin
                    w_hist_we  = 1'b1;
                    ptr_d      = ptr_q + 8'd1;
                    move_cnt_d = move_cnt_q + 8'd1;
                    state_d    = S_JUDGE;
                end
                S_JUDGE: begin
                    if (check_done) begin
                        if (check_win) begin
                            winner_d  = crt_player_q ? 2'b01 : 2'b10;
                            running_d = 1'b0;
                            state_d   = S_OVER;
                        end else if (move_cnt_q == C_MAX_MOVES) begin
                            draw_d    = 1'b1;
                            running_d = 1'b0;
                            state_d   = S_OVER;
                        end else begin
                            crt_player_d = ~crt_player_q;
                            state_d      = S_READY;
                        end
                    end
                end
                S_RETRACT: begin
                    state_d = S_READY;
                end
                S_OVER: begin
                    if (retract_req && (move_cnt_q != 8'd0)) begin
                        w_do_retract = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Undo: pop the newest stone; its color follows from stack depth
            if (w_do_retract) begin
                retract_d    = 1'b1;
                wr_i_d       = w_pop[7:4];
                wr_j_d       = w_pop[3:0];
                wr_color_d   = w_cnt_m1[0];
                crt_player_d = w_cnt_m1[0];
                ptr_d        = ptr_q - 8'd1;
                move_cnt_d   = w_cnt_m1;
                winner_d     = 2'b00;
                draw_d       = 1'b0;
                running_d    = 1'b1;
                state_d      = S_RETRACT;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q      <= S_IDLE;
            consider_i_q <= 4'd0;
            consider_j_q <= 4'd0;
            clr_q        <= 1'b0;
            write_q      <= 1'b0;
            retract_q    <= 1'b0;
            wr_i_q       <= 4'd0;
            wr_j_q       <= 4'd0;
            wr_color_q   <= 1'b0;
            crt_player_q <= 1'b0;
            running_q    <= 1'b0;
            winner_q     <= 2'b00;
            draw_q       <= 1'b0;
            move_cnt_q   <= 8'd0;
            reject_q     <= 1'b0;
            ptr_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            consider_i_q <= consider_i_d;
            consider_j_q <= consider_j_d;
            clr_q        <= clr_d;
            write_q      <= write_d;
            retract_q    <= retract_d;
            wr_i_q       <= wr_i_d;
            wr_j_q       <= wr_j_d;
            wr_color_q   <= wr_color_d;
            crt_player_q <= crt_player_d;
            running_q    <= running_d;
            winner_q     <= winner_d;
            draw_q       <= draw_d;
            move_cnt_q   <= move_cnt_d;
            reject_q     <= reject_d;
            ptr_q        <= ptr_d;
        end
    end

    // History RAM write port; contents need no reset
    always_ff @(posedge clk) begin
        if (w_hist_we) begin
            hist_mem[ptr_q] <= {wr_i_q, wr_j_q};
        end
    end

    assign consider_i   = consider_i_q;
    assign consider_j   = consider_j_q;
    assign clr          = clr_q;
    assign write        = write_q;
    assign retract      = retract_q;
    assign write_i      = wr_i_q;
    assign write_j      = wr_j_q;
    assign write_color  = wr_color_q;
    assign crt_player   = crt_player_q;
    assign game_running = running_q;
    assign winner       = winner_q;
    assign draw         = draw_q;
    assign move_cnt     = move_cnt_q;
    assign reject       = reject_q;

endmodule
`default_nettype wire
